// File: rtl/team_08_input_pkg.sv
// rtl/team_08_input_pkg.sv - shared types and defaults for the input conditioner
package team_08_input_pkg;

    typedef enum logic [1:0] {
        STABLE_LO,
        ARM_HI,
        STABLE_HI,
        ARM_LO
    } deb_state_t;

    localparam int SYNC_STAGES_DEFAULT = 2;
    localparam int DEB_CYCLES_DEFAULT  = 10000;
    localparam int HOLD_CYCLES_DEFAULT = 50000;

endpackage

// File: rtl/team_08_debounce_ch.sv
// rtl/team_08_debounce_ch.sv - one-input synchronizer plus debounce state machine
module team_08_debounce_ch
    import team_08_input_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_x;
    deb_state_t             state, state_next;
    logic [CW-1:0]          cnt, cnt_next;
    logic                   level_q, level_next;

    assign sync_x = sync_q[SYNC_STAGES-1];
    assign level  = level_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q  <= '0;
            state   <= STABLE_LO;
            cnt     <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
            state   <= state_next;
            cnt     <= cnt_next;
            level_q <= level_next;
        end
    end

    // rise/fall are strobes for the edge on which level_q is about to change
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        level_next = level_q;
        rise       = 1'b0;
        fall       = 1'b0;
        case (state)
            STABLE_LO: begin
                if (sync_x) begin
                    state_next = ARM_HI;
                    cnt_next   = '0;
                end
            end
            ARM_HI: begin
                if (!sync_x) begin
                    state_next = STABLE_LO;
                end else if (cnt == CNT_LAST) begin
                    state_next = STABLE_HI;
                    level_next = 1'b1;
                    rise       = 1'b1;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            STABLE_HI: begin
                if (!sync_x) begin
                    state_next = ARM_LO;
                    cnt_next   = '0;
                end
            end
            ARM_LO: begin
                if (sync_x) begin
                    state_next = STABLE_HI;
                end else if (cnt == CNT_LAST) begin
                    state_next = STABLE_LO;
                    level_next = 1'b0;
                    fall       = 1'b1;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: state_next = STABLE_LO;
        endcase
    end

endmodule

// File: rtl/team_08_input_conditioner.sv
// rtl/team_08_input_conditioner.sv - debounced jump/mode/soft-reset front end
module team_08_input_conditioner
    import team_08_input_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int HOLD_CYCLES     = HOLD_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic up_raw,
    input  logic mode_raw,
    input  logic srst_raw,
    output logic up_level,
    output logic up_pulse,
    output logic up_hold,
    output logic mode_sel,
    output logic mode_changed,
    output logic soft_rst_n
);

    localparam int HW = $clog2(HOLD_CYCLES) + 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

    logic          up_rise, up_fall;
    logic          mode_rise, mode_fall;
    logic          srst_level, srst_rise, srst_fall;
    logic [HW-1:0] hold_cnt;
    logic          srst_unused;

    team_08_debounce_ch #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .clk(clk), .reset(reset), .raw(up_raw),
        .level(up_level), .rise(up_rise), .fall(up_fall)
    );

    team_08_debounce_ch #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .clk(clk), .reset(reset), .raw(mode_raw),
        .level(mode_sel), .rise(mode_rise), .fall(mode_fall)
    );

    team_08_debounce_ch #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_srst (
        .clk(clk), .reset(reset), .raw(srst_raw),
        .level(srst_level), .rise(srst_rise), .fall(srst_fall)
    );

    assign srst_unused = srst_rise | srst_fall;

    // Counting starts the cycle after up_level rises; clears on the falling edge itself
    always_ff @(posedge clk) begin
        if (!reset) begin
            hold_cnt     <= '0;
            up_pulse     <= 1'b0;
            mode_changed <= 1'b0;
        end else begin
            up_pulse     <= up_rise;
            mode_changed <= mode_rise | mode_fall;
            if (!up_level || up_fall) begin
                hold_cnt <= '0;
            end else if (hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + HW'(1);
            end
        end
    end

    assign up_hold    = (hold_cnt == HOLD_MAX);
    assign soft_rst_n = ~srst_level;

endmodule
